// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter with bounded bursts.
// The winner's data is captured into a single output register stage.
// A valid/ready handshake is used on both requester sides and on the output side.
// Optional build macro MUX_ARB_STATS_EN adds saturating per-requester grant counters.
module mux_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
`ifdef MUX_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] a_grants,
   output logic [CNT_W-1:0] b_grants
`endif
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   state_t           state_q;
   logic [7:0]       burst_cnt_q;
   logic [7:0]       burst_cnt_d;
   logic             last_owner_q;   // 0 = A, 1 = B
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_src_q;

   logic             load;
   logic             win_a;
   logic             win_b;
   logic             at_max;
   logic             xfer_a;
   logic             xfer_b;

   // The output register can take a new beat when it is empty or being drained.
   assign load   = !out_valid_q | out_ready;
   assign at_max = (burst_cnt_q >= 8'(MAX_BURST));

   // Winner selection: the owner keeps the path until its burst is used up
   // while the other side waits. A lone requester keeps winning at saturation.
   always_comb begin
      win_a = 1'b0;
      win_b = 1'b0;
      case (state_q)
         OWN_A: begin
            if (a_valid && (!at_max || !b_valid)) win_a = 1'b1;
            else if (b_valid)                      win_b = 1'b1;
         end
         OWN_B: begin
            if (b_valid && (!at_max || !a_valid)) win_b = 1'b1;
            else if (a_valid)                      win_a = 1'b1;
         end
         default: begin
            if (a_valid && b_valid) begin
               if (last_owner_q) win_a = 1'b1;
               else              win_b = 1'b1;
            end else if (a_valid) begin
               win_a = 1'b1;
            end else if (b_valid) begin
               win_b = 1'b1;
            end
         end
      endcase
   end

   // Readies are forced low while reset is held.
   assign a_ready = load & win_a & !rst;
   assign b_ready = load & win_b & !rst;
   assign xfer_a  = a_valid & a_ready;
   assign xfer_b  = b_valid & b_ready;

   // Burst count for the next beat: continue and saturate for the same owner, else restart at 1.
   always_comb begin
      burst_cnt_d = 8'd1;
      if ((state_q == OWN_A && xfer_a) || (state_q == OWN_B && xfer_b)) begin
         burst_cnt_d = at_max ? burst_cnt_q : burst_cnt_q + 8'd1;
      end
   end

   // Arbitration state and the output register stage; a stall holds everything.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         burst_cnt_q  <= 8'd0;
         last_owner_q <= 1'b1;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= 1'b0;
      end else if (load) begin
         if (xfer_a) begin
            state_q      <= OWN_A;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= 1'b0;
            out_valid_q  <= 1'b1;
            out_data_q   <= a_data;
            out_src_q    <= 1'b0;
         end else if (xfer_b) begin
            state_q      <= OWN_B;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= 1'b1;
            out_valid_q  <= 1'b1;
            out_data_q   <= b_data;
            out_src_q    <= 1'b1;
         end else begin
            state_q      <= IDLE;
            burst_cnt_q  <= 8'd0;
            out_valid_q  <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef MUX_ARB_STATS_EN
   logic [CNT_W-1:0] a_grants_q;
   logic [CNT_W-1:0] b_grants_q;

   // Per-requester accepted-beat counters that saturate at all-ones.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         a_grants_q <= '0;
         b_grants_q <= '0;
      end else begin
         if (xfer_a && (a_grants_q != '1)) a_grants_q <= a_grants_q + 1'b1;
         if (xfer_b && (b_grants_q != '1)) b_grants_q <= b_grants_q + 1'b1;
      end
   end

   assign a_grants = a_grants_q;
   assign b_grants = b_grants_q;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: a vector table plus hand-written corner sequences.
// Accepted beats go into a scoreboard queue and are checked when they reach the output.
module tb_mux_arbiter;

   logic       sysclk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid, out_ready;
   logic [7:0] a_data, b_data;

   logic       a_ready4, b_ready4, out_valid4, out_src4;
   logic [7:0] out_data4;
   logic       a_ready1, b_ready1, out_valid1, out_src1;
   logic [7:0] out_data1;
`ifdef MUX_ARB_STATS_EN
   logic [15:0] a_grants4, b_grants4, a_grants1, b_grants1;
`endif

   always #5 sysclk = ~sysclk;

   mux_arbiter #(.WIDTH(8), .MAX_BURST(4), .CNT_W(16)) dut (
      .sysclk(sysclk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
      .out_valid(out_valid4), .out_data(out_data4), .out_src(out_src4),
      .out_ready(out_ready)
`ifdef MUX_ARB_STATS_EN
      , .a_grants(a_grants4), .b_grants(b_grants4)
`endif
   );

   mux_arbiter #(.WIDTH(8), .MAX_BURST(1), .CNT_W(16)) dut1 (
      .sysclk(sysclk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
      .out_valid(out_valid1), .out_data(out_data1), .out_src(out_src1),
      .out_ready(out_ready)
`ifdef MUX_ARB_STATS_EN
      , .a_grants(a_grants1), .b_grants(b_grants1)
`endif
   );

   // The selected instance is the one under check.
   logic       sel = 1'b0;
   logic       cur_ar, cur_br, cur_ov, cur_os;
   logic [7:0] cur_od;
   assign cur_ar = sel ? a_ready1   : a_ready4;
   assign cur_br = sel ? b_ready1   : b_ready4;
   assign cur_ov = sel ? out_valid1 : out_valid4;
   assign cur_os = sel ? out_src1   : out_src4;
   assign cur_od = sel ? out_data1  : out_data4;

   typedef struct packed { logic src; logic [7:0] data; } beat_t;
   typedef struct {
      logic av; logic [7:0] ad; logic bv; logic [7:0] bd; logic ordy;
      logic ea; logic eb;
   } vec_t;

   beat_t q[$];
   logic  pend = 1'b0;
   int    total = 0;
   int    bad   = 0;
   vec_t  vecs[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive, check the previously accepted beat and the readies, then record.
   task automatic step(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd,
                       input logic ordy, input logic ea, input logic eb);
      beat_t e;
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
      @(negedge sysclk);
      if (pend) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got no queued beat expected one at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("out_valid", 32'(cur_ov), 32'd1);
            chk("out_src",   32'(cur_os), 32'(e.src));
            chk("out_data",  32'(cur_od), 32'(e.data));
         end
      end
      chk("a_ready", 32'(cur_ar), 32'(ea));
      chk("b_ready", 32'(cur_br), 32'(eb));
      pend = 1'b0;
      if (ea) begin
         e.src = 1'b0; e.data = ad; q.push_back(e); pend = 1'b1;
      end else if (eb) begin
         e.src = 1'b1; e.data = bd; q.push_back(e); pend = 1'b1;
      end
      $display("beat t=%0t av=%0b bv=%0b ordy=%0b ar=%0b br=%0b ov=%0b src=%0b data=%02h",
               $time, av, bv, ordy, cur_ar, cur_br, cur_ov, cur_os, cur_od);
      @(posedge sysclk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Both requesters held valid: four A beats, four B beats, then A again.
      for (int i = 0; i < 9; i++) begin
         vecs[i] = '{1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1,
                     (i < 4 || i == 8), (i >= 4 && i < 8)};
      end
      // B alone: granted every cycle even with its burst count saturated.
      for (int i = 9; i < 19; i++) begin
         vecs[i] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
      end

      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; out_ready = 1'b1;
      @(posedge sysclk); @(posedge sysclk); #1;
      chk("rst_out_valid", 32'(out_valid4), 32'd0);
      chk("rst_out_data",  32'(out_data4),  32'd0);
      chk("rst_out_src",   32'(out_src4),   32'd0);
      chk("rst_a_ready",   32'(a_ready4),   32'd0);
      chk("rst_b_ready",   32'(b_ready4),   32'd0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy, vecs[i].ea, vecs[i].eb);
      end

      // Output stall: nothing accepted, output register frozen.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'hC0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
         chk("stall_valid", 32'(out_valid4), 32'd1);
         chk("stall_data",  32'(out_data4),  32'h5A);
         chk("stall_src",   32'(out_src4),   32'd1);
      end
      // Released: B's burst is used up, so A is taken in the same cycle.
      step(1'b1, 8'hC2, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'hC4, 1'b1, 8'hC5, 1'b1, 1'b1, 1'b0);

      // Reset mid-cycle at burst count 2: the output drops at once.
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid4), 32'd0);
      chk("midrst_a_ready",   32'(a_ready4),   32'd0);
      chk("midrst_b_ready",   32'(b_ready4),   32'd0);
      rst = 1'b0;
      q.delete(); pend = 1'b0;
      step(1'b1, 8'hD0, 1'b1, 8'hD1, 1'b1, 1'b1, 1'b0);

      // A alone for two beats, one idle cycle, then both: B wins from IDLE.
      step(1'b1, 8'hE0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'hE1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("idle_out_valid", 32'(out_valid4), 32'd0);
      step(1'b1, 8'hE2, 1'b1, 8'hE3, 1'b1, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Burst of one: strict alternation on the second instance.
      sel = 1'b1;
      rst = 1'b1;
      @(posedge sysclk); #1;
      rst = 1'b0;
      q.delete(); pend = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'h30 + 8'(i), 1'b1, 8'h40 + 8'(i), 1'b1, (i % 2 == 0), (i % 2 == 1));
      end
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef MUX_ARB_STATS_EN
      chk("a_grants", 32'(a_grants1), 32'd4);
      chk("b_grants", 32'(b_grants1), 32'd4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
